decode_scoreboard: RTL and testbench
====================================

DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001: Parameter MAX_PEND, default 4, maximum outstanding long-latency writes (legal range 1-7).
REQ-002: clk  input  1  sole clock, all state on rising edge.
REQ-003: reset  input  1  asynchronous, active-low reset.
REQ-004: id_valid  input  1  decode stage holds a valid instruction.
REQ-005: id_rs1, id_rs2, id_rd  input  5 each  register indices from decode.
REQ-006: id_use_rs1, id_use_rs2  input  1 each  instruction reads that source.
REQ-007: id_reg_write  input  1  instruction writes id_rd.
REQ-008: id_long  input  1  write is long-latency (load/mul/div), returned later via wb port.
REQ-009: wb_valid  input  1, wb_rd  input  5  long-latency result written to register file this cycle.
REQ-010: drain_req  input  1  request to quiesce all outstanding long ops.
REQ-011: stall  output  1  decode must hold; issue  output  1  instruction accepted this cycle.
REQ-012: busy  output  32  pending-write vector, bit n = register n awaiting long result.
REQ-013: pend_count  output  3  outstanding long ops; drained  output  1; wb_err  output  1 sticky.

Function
REQ-014: Hazard evaluated on registered busy only; no same-cycle writeback bypass.
REQ-015: raw = (id_use_rs1 & busy[id_rs1]) | (id_use_rs2 & busy[id_rs2]); waw = id_reg_write & busy[id_rd]; full = id_long & id_reg_write & (pend_count == MAX_PEND).
REQ-016: Register x0 never hazards; busy[0] is constant 0 and id_rd == 0 never sets busy or increments pend_count.
REQ-017: stall = id_valid & (raw | waw | full | state != RUN); issue = id_valid & ~stall; both combinational.
REQ-018: On issue with id_long & id_reg_write & id_rd != 0: busy[id_rd] set, pend_count +1 at next edge.
REQ-019: On wb_valid with busy[wb_rd] = 1: busy[wb_rd] cleared, pend_count -1 at next edge.
REQ-020: Issue-set and wb-clear in the same cycle both take effect; pend_count net change 0.
REQ-021: wb_valid to non-busy register (incl. x0): no state change except wb_err set to 1, held until reset.
REQ-022: pend_count never wraps; full guarantees no increment past MAX_PEND, underflow prevented by REQ-021.
REQ-023: FSM states RUN, DRAIN, HALT; RUN -> DRAIN when drain_req = 1.
REQ-024: DRAIN -> HALT when pend_count == 0 (same-edge if already 0); wb continues to be accepted in DRAIN.
REQ-025: HALT -> RUN when drain_req = 0; drained = 1 exactly while in HALT (registered).
REQ-026: drain_req deasserted during DRAIN returns to RUN at next edge.

Reset
REQ-027: While reset = 0: busy = 0, pend_count = 0, wb_err = 0, drained = 0, state = RUN, perf counter = 0, independent of clk.
REQ-028: Reset mid-operation discards all pending entries; later wb for them raise wb_err.

Configuration
REQ-029: Macro SCOREBOARD_PERF_EN defined: adds output stall_cycles 32 bits, +1 each cycle id_valid & stall, saturating at 0xFFFFFFFF.
REQ-030: SCOREBOARD_PERF_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-031: Load to x5 issued, next cycle id rs1=5 use_rs1=1 -> stall=1 until cycle after wb_valid wb_rd=5, then issue=1.
REQ-032: MAX_PEND=4, four long issues to x1-x4, fifth long to x6 -> stall=1, pend_count=4; wb x1 -> issues next cycle, pend_count=4.
REQ-033: Long issue to x0 -> busy=0, pend_count=0; wb_rd=7 with busy[7]=0 -> wb_err=1, persists until reset.
REQ-034: Two pending, drain_req=1 -> stall=1, state DRAIN; two wbs -> drained=1 next edge; drain_req=0 -> drained=0, issue resumes.
REQ-035: Same cycle issue long x9 and wb x3 (busy) -> busy[9]=1, busy[3]=0, pend_count unchanged.
REQ-036: Assert reset=0 with 3 pending, no clock edge -> all outputs zero immediately; with SCOREBOARD_PERF_EN, 10 stalled cycles -> stall_cycles=10.

Source files
------------

// File: rtl/decode_scoreboard_if.sv
// Decode-to-scoreboard handshake plus the long-latency writeback port.
// The master side is the decode/writeback pipeline; the slave side is the scoreboard.
interface decode_scoreboard_if;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       id_reg_write;
    logic       id_long;
    logic       stall;
    logic       issue;
    logic       wb_valid;
    logic [4:0] wb_rd;

    modport master (
        output id_valid,
        output id_rs1,
        output id_rs2,
        output id_rd,
        output id_use_rs1,
        output id_use_rs2,
        output id_reg_write,
        output id_long,
        output wb_valid,
        output wb_rd,
        input  stall,
        input  issue
    );

    modport slave (
        input  id_valid,
        input  id_rs1,
        input  id_rs2,
        input  id_rd,
        input  id_use_rs1,
        input  id_use_rs2,
        input  id_reg_write,
        input  id_long,
        input  wb_valid,
        input  wb_rd,
        output stall,
        output issue
    );
endinterface

// File: rtl/decode_scoreboard.sv
// Register scoreboard for the decode stage: tracks long-latency writes, stalls on RAW/WAW/full,
// and supports a drain/halt handshake. Optional stall counter enabled by SCOREBOARD_PERF_EN.
module decode_scoreboard #(
    parameter int unsigned MAX_PEND = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    decode_scoreboard_if.slave   sb,
    input  logic                 drain_req,
    output logic [31:0]          busy,
    output logic [2:0]           pend_count,
    output logic                 drained,
`ifdef SCOREBOARD_PERF_EN
    output logic [31:0]          stall_cycles,
`endif
    output logic                 wb_err
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StHalt  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] busy_q, busy_d;
    logic [2:0]  pend_q, pend_d;
    logic        wb_err_q, wb_err_d;

    logic raw, waw, full;
    logic issue_long;
    logic wb_hit;
    logic wb_miss;

    // Hazards look only at registered busy; a same-cycle writeback does not unblock decode.
    always_comb begin
        raw  = (sb.id_use_rs1 & busy_q[sb.id_rs1]) | (sb.id_use_rs2 & busy_q[sb.id_rs2]);
        waw  = sb.id_reg_write & busy_q[sb.id_rd];
        full = sb.id_long & sb.id_reg_write & (pend_q == 3'(MAX_PEND));
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (drain_req) state_d = StDrain;
            end
            StDrain: begin
                if (!drain_req) begin
                    state_d = StRun;
                end else if (pend_q == 3'd0) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (!drain_req) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // Outputs.
    always_comb begin
        sb.stall = sb.id_valid & (raw | waw | full | (state_q != StRun));
        sb.issue = sb.id_valid & ~sb.stall;
        drained  = (state_q == StHalt);
    end

    always_comb begin
        issue_long = sb.issue & sb.id_long & sb.id_reg_write & (sb.id_rd != 5'd0);
        wb_hit     = sb.wb_valid & busy_q[sb.wb_rd];
        wb_miss    = sb.wb_valid & ~busy_q[sb.wb_rd];
    end

    // A WAW stall keeps issue_long and wb_hit from ever targeting the same register.
    always_comb begin
        busy_d = busy_q;
        if (issue_long) busy_d[sb.id_rd] = 1'b1;
        if (wb_hit)     busy_d[sb.wb_rd] = 1'b0;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        pend_d = pend_q;
        unique case ({issue_long, wb_hit})
            2'b10:   pend_d = pend_q + 3'd1;
            2'b01:   pend_d = pend_q - 3'd1;
            default: pend_d = pend_q;
        endcase
    end

    always_comb begin
        wb_err_d = wb_err_q | wb_miss;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q   <= 32'd0;
            pend_q   <= 3'd0;
            wb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            pend_q   <= pend_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign busy       = {busy_q[31:1], 1'b0};
    assign pend_count = pend_q;
    assign wb_err     = wb_err_q;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (sb.stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed self-checking bench for decode_scoreboard (MAX_PEND = 4).
// Covers the perf counter as well when built with SCOREBOARD_PERF_EN.
module tb_decode_scoreboard;

    logic        clk;
    logic        reset;
    logic        drain_req;
    logic [31:0] busy;
    logic [2:0]  pend_count;
    logic        drained;
    logic        wb_err;
`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    decode_scoreboard_if sb ();

    decode_scoreboard #(
        .MAX_PEND (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sb           (sb),
        .drain_req    (drain_req),
        .busy         (busy),
        .pend_count   (pend_count),
        .drained      (drained),
`ifdef SCOREBOARD_PERF_EN
        .stall_cycles (stall_cycles),
`endif
        .wb_err       (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic u1, input logic u2,
                          input logic wr, input logic lng);
        sb.id_valid     = v;
        sb.id_rs1       = rs1;
        sb.id_rs2       = rs2;
        sb.id_rd        = rd;
        sb.id_use_rs1   = u1;
        sb.id_use_rs2   = u2;
        sb.id_reg_write = wr;
        sb.id_long      = lng;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd);
        sb.wb_valid = v;
        sb.wb_rd    = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        drain_req = 1'b0;
        idle();
        set_wb(1'b0, 5'd0);
        #3;
        check("rst_busy", busy, 32'h0);
        check("rst_pend", 32'(pend_count), 32'd0);
        check("rst_wb_err", 32'(wb_err), 32'd0);
        check("rst_drained", 32'(drained), 32'd0);
        check("rst_issue", 32'(sb.issue), 32'd0);
`ifdef SCOREBOARD_PERF_EN
        check("rst_stall_cycles", stall_cycles, 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();

        // RAW on a pending load, released the cycle after its writeback.
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        #1 check("load_x5_issue", 32'(sb.issue), 32'd1);
        step();
        set_id(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("raw_stall", 32'(sb.stall), 32'd1);
        check("raw_busy", busy, 32'h0000_0020);
        check("raw_pend", 32'(pend_count), 32'd1);
        step();
        check("raw_stall_hold", 32'(sb.stall), 32'd1);
        set_wb(1'b1, 5'd5);
        #1 check("raw_no_bypass", 32'(sb.stall), 32'd1);
        step();
        set_wb(1'b0, 5'd0);
        #1 check("raw_release_issue", 32'(sb.issue), 32'd1);
        check("raw_release_busy", busy, 32'h0);
        check("raw_release_pend", 32'(pend_count), 32'd0);
        idle();

        // Fill to MAX_PEND, then a writeback frees one slot.
        for (int i = 1; i <= 4; i++) begin
            set_id(1'b1, 5'd0, 5'd0, 5'(i), 1'b0, 1'b0, 1'b1, 1'b1);
            step();
        end
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1);
        #1 check("full_stall", 32'(sb.stall), 32'd1);
        check("full_pend", 32'(pend_count), 32'd4);
        check("full_busy", busy, 32'h0000_001E);
        set_wb(1'b1, 5'd1);
        #1 check("full_stall_during_wb", 32'(sb.stall), 32'd1);
        step();
        set_wb(1'b0, 5'd0);
        #1 check("full_then_issue", 32'(sb.issue), 32'd1);
        check("full_after_wb_pend", 32'(pend_count), 32'd3);
        step();
        idle();
        #1 check("full_refill_pend", 32'(pend_count), 32'd4);
        check("full_refill_busy", busy, 32'h0000_005C);

        // Simultaneous issue-set and writeback-clear.
        set_wb(1'b1, 5'd2);
        step();
        set_wb(1'b0, 5'd0);
        check("wb_x2_pend", 32'(pend_count), 32'd3);
        check("wb_x2_busy", busy, 32'h0000_0058);
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1);
        set_wb(1'b1, 5'd3);
        #1 check("same_cycle_issue", 32'(sb.issue), 32'd1);
        step();
        idle();
        set_wb(1'b0, 5'd0);
        #1 check("same_cycle_busy", busy, 32'h0000_0250);
        check("same_cycle_pend", 32'(pend_count), 32'd3);

        // WAW, RAW on rs2, and x0 never hazards.
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 check("waw_stall", 32'(sb.stall), 32'd1);
        set_id(1'b1, 5'd0, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check("raw_rs2_stall", 32'(sb.stall), 32'd1);
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 check("x0_no_hazard", 32'(sb.issue), 32'd1);
        idle();

        // Drain with two pending.
        set_wb(1'b1, 5'd9);
        step();
        set_wb(1'b0, 5'd0);
        check("pre_drain_pend", 32'(pend_count), 32'd2);
        drain_req = 1'b1;
        step();
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("drain_stall", 32'(sb.stall), 32'd1);
        check("drain_not_drained", 32'(drained), 32'd0);
        set_wb(1'b1, 5'd4);
        step();
        set_wb(1'b1, 5'd6);
        step();
        set_wb(1'b0, 5'd0);
        check("drain_pend_zero", 32'(pend_count), 32'd0);
        check("drain_wait", 32'(drained), 32'd0);
        step();
        check("halt_drained", 32'(drained), 32'd1);
        check("halt_stall", 32'(sb.stall), 32'd1);
        drain_req = 1'b0;
        step();
        check("resume_drained", 32'(drained), 32'd0);
        check("resume_issue", 32'(sb.issue), 32'd1);
        idle();

        // Drain abandoned while entries are still pending.
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        step();
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("drain_abort_issue", 32'(sb.issue), 32'd1);
        idle();

        // Long write to x0 is ignored; stray writeback is sticky.
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1 check("x0_long_issue", 32'(sb.issue), 32'd1);
        step();
        idle();
        #1 check("x0_long_pend", 32'(pend_count), 32'd1);
        check("x0_long_busy", busy, 32'h0000_0080);
        set_wb(1'b1, 5'd8);
        step();
        set_wb(1'b0, 5'd0);
        check("stray_wb_err", 32'(wb_err), 32'd1);
        check("stray_busy", busy, 32'h0000_0080);
        check("stray_pend", 32'(pend_count), 32'd1);
        step();
        step();
        check("wb_err_sticky", 32'(wb_err), 32'd1);

        // Asynchronous reset with three pending, between clock edges.
        set_id(1'b1, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd0, 5'd0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd10, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("pre_reset_pend", 32'(pend_count), 32'd3);
        check("pre_reset_stall", 32'(sb.stall), 32'd1);
        #1 reset = 1'b0;
        #1 check("async_busy", busy, 32'h0);
        check("async_pend", 32'(pend_count), 32'd0);
        check("async_wb_err", 32'(wb_err), 32'd0);
        check("async_drained", 32'(drained), 32'd0);
        check("async_stall", 32'(sb.stall), 32'd0);
        idle();
        @(negedge clk);
        reset = 1'b1;
        set_wb(1'b1, 5'd10);
        step();
        set_wb(1'b0, 5'd0);
        check("discarded_wb_err", 32'(wb_err), 32'd1);
        check("discarded_pend", 32'(pend_count), 32'd0);

`ifdef SCOREBOARD_PERF_EN
        @(negedge clk);
        reset = 1'b0;
        #1 check("perf_rst", stall_cycles, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step();
        idle();
        #1 check("perf_stall_cycles", stall_cycles, 32'd10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
